pla_equiv_sweeper: RTL

Sequential controller that exhaustively exercises an 8-input, single-output combinational benchmark function and checks it against a golden copy. It drives every input vector, one per clock, into two netlists of the same PLA function. Typically these are the original netlist and the mockturtle-optimised netlist. The block compares their outputs, counts mismatches and records the first failing vector. It sits in the equivalence-check harness, with both combinational netlists hung directly off its `x_out` bus.

---
 rtl/pla_sweep_pkg.sv | 20 ++
 rtl/pla_vec_counter.sv | 28 ++
 rtl/pla_equiv_sweeper.sv | 106 ++++++++++
 3 files changed

// File: rtl/pla_sweep_pkg.sv
// pla_sweep_pkg: shared state encoding and default sizes for the PLA equivalence sweeper.
// Rev 1.0
`default_nettype none
package pla_sweep_pkg;

  localparam int PLA_NUM_IN = 8;
  localparam int PLA_CNT_W  = PLA_NUM_IN + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SWEEP = S_SWEEP,
    ST_DONE  = S_DONE
  } sweep_state_t;

endpackage
`default_nettype wire

// File: rtl/pla_vec_counter.sv
// pla_vec_counter: W-bit input-vector counter with clear, enable and terminal count.
// Rev 1.0
`default_nettype none
module pla_vec_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = &cnt;

endmodule
`default_nettype wire

// File: rtl/pla_equiv_sweeper.sv
// pla_equiv_sweeper: drives every input vector into two netlists, counts output mismatches.
// Rev 1.0
`default_nettype none
module pla_equiv_sweeper
  import pla_sweep_pkg::*;
#(
  parameter int NUM_IN = PLA_NUM_IN,
  parameter int CNT_W  = NUM_IN + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              stop_on_fail,
  output logic [NUM_IN-1:0] x_out,
  input  logic              y_ref,
  input  logic              y_opt,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [NUM_IN-1:0] first_fail,
  output logic              first_fail_vld
);

  sweep_state_t state;
  logic         sof_latched;
  logic         mis;
  logic         accept;
  logic         evaluate;
  logic         vec_clr;
  logic         vec_en;
  logic         vec_tc;

  assign mis      = y_ref ^ y_opt;
  assign accept   = (state == ST_IDLE) && start;
  assign evaluate = (state == ST_SWEEP) && !abort;

  assign vec_clr = accept;
  // Freeze the vector on abort or on a stopping failure so x_out shows it afterwards.
  assign vec_en  = evaluate && !(mis && sof_latched);

  pla_vec_counter #(
    .W (NUM_IN)
  ) u_vec_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (vec_clr),
    .en    (vec_en),
    .cnt   (x_out),
    .tc    (vec_tc)
  );

  assign busy = (state == ST_SWEEP);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      sof_latched    <= 1'b0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sof_latched    <= stop_on_fail;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
            state          <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            if (mis) begin
              mismatch_cnt <= mismatch_cnt + CNT_W'(1);
              if (!first_fail_vld) begin
                first_fail     <= x_out;
                first_fail_vld <= 1'b1;
              end
            end
            if ((mis && sof_latched) || vec_tc) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Only reachable without abort, so the count alone decides the verdict.
          pass  <= (mismatch_cnt == '0);
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
